ss3_datastack_param: RTL and testbench
======================================

// Module: ss3_datastack_param
// PURPOSE
//  Third-generation processor data stack. Replaces the fixed 16-bit/5-source stack.
//  Width, depth and source count are parametrised; top-of-stack is held in register TR.
//  Adds explicit push/pop/swap opcodes, a next-on-stack (NOS) read port,
//  full/empty status and sticky overflow/underflow flags.
//  Sits between the register-source muxing in the datapath and the ALU operand inputs.
// PARAMETERS
//  WIDTH   16  data word width in bits
//  DEPTH   16  number of entries below TR (stack RAM entries); must be >= 2
//  NSRC    5   number of selectable TR load sources
//  CNT_W   $clog2(DEPTH+1)  derived (localparam); width of count
//  SEL_W   $clog2(NSRC)     derived (localparam); width of tr_src
// PORTS
//  CLK        in   1            clock; all state updates on rising edge
//  reset      in   1            asynchronous, active-high reset
//  op         in   2            00 NOP, 01 PUSH, 10 POP, 11 SWAP
//  tr_write   in   1            load TR from selected source this cycle
//  tr_src     in   SEL_W        source select into src_bus
//  src_bus    in   NSRC*WIDTH   packed sources; source k = src_bus[k*WIDTH +: WIDTH]
//  err_clear  in   1            clears the ovf/unf sticky flags
//  tos        out  WIDTH        current TR value (registered)
//  nos        out  WIDTH        RAM[count-1]; 0 when empty (combinational read)
//  count      out  CNT_W        entries in RAM (TR excluded), 0..DEPTH
//  full       out  1            count == DEPTH
//  empty      out  1            count == 0
//  ovf        out  1            sticky: PUSH attempted while full
//  unf        out  1            sticky: POP/SWAP attempted while empty
// BEHAVIOUR
//  Reset (async, any time, including mid-operation):
//   - tos=0, count=0, ovf=0, unf=0, empty=1, full=0.
//   - RAM contents are not reset. nos reads 0 because the stack is empty.
//   - First edge after reset deasserts is a normal cycle.
//  src_sel = src_bus slice tr_src. tr_src >= NSRC selects 0.
//  All updates complete in 1 cycle. Results are visible on the outputs after that edge.
//  NOP:  tos <= tr_write ? src_sel : tos.
//  PUSH, !full:
//   - RAM[count] <= tos; count <= count+1.
//   - tos <= tr_write ? src_sel : tos (tr_write=0 gives DUP).
//  POP, !empty:
//   - count <= count-1.
//   - tos <= tr_write ? src_sel : RAM[count-1].
//  SWAP, !empty:
//   - RAM[count-1] <= tos; tos <= RAM[count-1].
//   - tr_write is ignored; count is unchanged.
//  Illegal cases:
//   - PUSH while full: no state change (tr_write also ignored); ovf <= 1.
//   - POP or SWAP while empty: no state change; unf <= 1.
//  Sticky flags:
//   - err_clear clears ovf and unf.
//   - If a new error occurs on the same edge as err_clear, the set wins.
//  Write port: one RAM write per cycle at most (PUSH or SWAP), so a single write port suffices.
//  count never wraps; it saturates at 0 and DEPTH via the illegal-op rules above.
// STRUCTURE
//  Package ss3_ds_pkg:
//   - op encodings (OP_NOP, OP_PUSH, OP_POP, OP_SWAP).
//   - WIDTH/DEPTH defaults shared with the datapath.
//  Sub-module ss3_ds_regfile:
//   - DEPTH x WIDTH, 1 synchronous write port, 1 asynchronous read port.
//   - No reset on the array.
//  Top level holds TR, count, flags, the source mux and the op decode.
// TESTING (default parameters unless stated)
//  1. Reset mid-stream: after 3 pushes, pulse reset between edges.
//     -> count=0, tos=0, empty=1, nos=0 immediately, without waiting for a clock edge.
//  2. Load and push: src_bus = {5,4,3,2,1}.
//     - tr_write=1, tr_src=2 (NOP) -> tos=3.
//     - Then PUSH with tr_src=4 -> tos=5, nos=3, count=1.
//  3. POP: from state of test 2, POP with tr_write=0 -> tos=3, count=0, empty=1.
//     DUP: PUSH with tr_write=0 -> tos=3, nos=3, count=1.
//  4. Fill: 16 pushes of values 1..16.
//     - -> full=1, nos=15, tos=16.
//     - 17th push -> ovf=1; tos, count and nos unchanged.
//     - err_clear -> ovf=0.
//  5. Underflow: POP and SWAP on an empty stack -> unf=1, tos unchanged.
//     err_clear together with an illegal POP on the same edge -> unf stays 1.
//  6. SWAP: tos=7, nos=9 -> tos=9, nos=7, count unchanged.
//     Re-run tests 2 and 4 with WIDTH=8, DEPTH=4, NSRC=3; also check tr_src=3 loads 0.

Source files
------------

// File: rtl/ss3_ds_pkg.sv
// ---------------------------------------------------------------------------
// ss3_ds_pkg
// Shared definitions for the third-generation processor data stack:
//   - ds_op_e : stack opcode encoding driven on the 'op' port
//   - DS_WIDTH / DS_DEPTH / DS_NSRC : default geometry shared with the datapath
// ---------------------------------------------------------------------------
package ss3_ds_pkg;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_SWAP = 2'b11
   } ds_op_e;

   localparam int DS_WIDTH = 16;
   localparam int DS_DEPTH = 16;
   localparam int DS_NSRC  = 5;

endpackage

// File: rtl/ss3_ds_regfile.sv
// ---------------------------------------------------------------------------
// ss3_ds_regfile
// Stack RAM below TR: DEPTH x WIDTH, one synchronous write port and one
// asynchronous (combinational) read port. The array has no reset.
// Ports:
//   clk_i    in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational)
// ---------------------------------------------------------------------------
module ss3_ds_regfile #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ss3_datastack_param.sv
// ---------------------------------------------------------------------------
// ss3_datastack_param
// Parametrised processor data stack. Top-of-stack lives in register TR; the
// DEPTH entries below it live in ss3_ds_regfile. Supports NOP/PUSH/POP/SWAP,
// a TR load from one of NSRC packed sources, full/empty status and sticky
// overflow/underflow flags.
// Ports:
//   CLK        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   op         in   2-bit opcode (ds_op_e)
//   tr_write   in   load TR from selected source
//   tr_src     in   source select (>= NSRC selects 0)
//   src_bus    in   NSRC packed WIDTH-bit sources
//   err_clear  in   clears ovf/unf (a new error on the same edge wins)
//   tos        out  TR value
//   nos        out  RAM[count-1], 0 when empty
//   count      out  entries in RAM (TR excluded)
//   full       out  count == DEPTH
//   empty      out  count == 0
//   ovf        out  sticky PUSH-while-full
//   unf        out  sticky POP/SWAP-while-empty
// ---------------------------------------------------------------------------
module ss3_datastack_param
   import ss3_ds_pkg::*;
#(
   parameter  int WIDTH = DS_WIDTH,
   parameter  int DEPTH = DS_DEPTH,
   parameter  int NSRC  = DS_NSRC,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int SEL_W = $clog2(NSRC)
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic [1:0]            op,
   input  logic                  tr_write,
   input  logic [SEL_W-1:0]      tr_src,
   input  logic [NSRC*WIDTH-1:0] src_bus,
   input  logic                  err_clear,
   output logic [WIDTH-1:0]      tos,
   output logic [WIDTH-1:0]      nos,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  empty,
   output logic                  ovf,
   output logic                  unf
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] tos_q, tos_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [WIDTH-1:0] src_sel;
   logic             full_w, empty_w;
   logic [AW-1:0]    top_addr;
   logic [AW-1:0]    push_addr;
   logic             rf_we;
   logic [AW-1:0]    rf_waddr;
   logic [WIDTH-1:0] rf_rdata;

   // Out-of-range selects fall through to the zero default.
   always_comb begin
      src_sel = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (tr_src == SEL_W'(k)) begin
            src_sel = src_bus[k*WIDTH +: WIDTH];
         end
      end
   end

   assign full_w  = (count_q == CNT_W'(DEPTH));
   assign empty_w = (count_q == '0);

   // Address arithmetic is done modulo 2^AW: count-1 is always < DEPTH when
   // it is used, so dropping the count MSB (count == DEPTH, power-of-two
   // DEPTH) still yields DEPTH-1.
   assign push_addr = count_q[AW-1:0];
   assign top_addr  = count_q[AW-1:0] - AW'(1);

   ss3_ds_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_regfile (
      .clk_i   (CLK),
      .we_i    (rf_we),
      .waddr_i (rf_waddr),
      .wdata_i (tos_q),
      .raddr_i (top_addr),
      .rdata_o (rf_rdata)
   );

   always_comb begin
      tos_d    = tos_q;
      count_d  = count_q;
      // Clear first so that an error raised below on the same edge wins.
      ovf_d    = ovf_q & ~err_clear;
      unf_d    = unf_q & ~err_clear;
      rf_we    = 1'b0;
      rf_waddr = push_addr;

      case (ds_op_e'(op))
         OP_NOP: begin
            if (tr_write) tos_d = src_sel;
         end
         OP_PUSH: begin
            if (full_w) begin
               ovf_d = 1'b1;
            end else begin
               rf_we   = 1'b1;
               count_d = count_q + CNT_W'(1);
               if (tr_write) tos_d = src_sel;
            end
         end
         OP_POP: begin
            if (empty_w) begin
               unf_d = 1'b1;
            end else begin
               count_d = count_q - CNT_W'(1);
               tos_d   = tr_write ? src_sel : rf_rdata;
            end
         end
         OP_SWAP: begin
            if (empty_w) begin
               unf_d = 1'b1;
            end else begin
               rf_we    = 1'b1;
               rf_waddr = top_addr;
               tos_d    = rf_rdata;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         tos_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         tos_q   <= tos_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign tos   = tos_q;
   assign nos   = empty_w ? '0 : rf_rdata;
   assign count = count_q;
   assign full  = full_w;
   assign empty = empty_w;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: tb/tb_ss3_datastack_param.sv
module tb_ss3_datastack_param;
   import ss3_ds_pkg::*;

   logic CLK = 1'b0;
   logic reset = 1'b1;
   always #5 CLK = ~CLK;

   // default-geometry instance (16x16, 5 sources)
   logic [1:0]  op_a;
   logic        trw_a, clr_a;
   logic [2:0]  src_a;
   logic [79:0] bus_a;
   logic [15:0] tos_a, nos_a;
   logic [4:0]  cnt_a;
   logic        full_a, empty_a, ovf_a, unf_a;

   // small instance (8-bit, depth 4, 3 sources)
   logic [1:0]  op_b;
   logic        trw_b, clr_b;
   logic [1:0]  src_b;
   logic [23:0] bus_b;
   logic [7:0]  tos_b, nos_b;
   logic [2:0]  cnt_b;
   logic        full_b, empty_b, ovf_b, unf_b;

   ss3_datastack_param dut_a (
      .CLK(CLK), .reset(reset), .op(op_a), .tr_write(trw_a), .tr_src(src_a),
      .src_bus(bus_a), .err_clear(clr_a), .tos(tos_a), .nos(nos_a),
      .count(cnt_a), .full(full_a), .empty(empty_a), .ovf(ovf_a), .unf(unf_a)
   );

   ss3_datastack_param #(.WIDTH(8), .DEPTH(4), .NSRC(3)) dut_b (
      .CLK(CLK), .reset(reset), .op(op_b), .tr_write(trw_b), .tr_src(src_b),
      .src_bus(bus_b), .err_clear(clr_b), .tos(tos_b), .nos(nos_b),
      .count(cnt_b), .full(full_b), .empty(empty_b), .ovf(ovf_b), .unf(unf_b)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int sel = 0;

   // reference model: a plain queue of the entries under TR
   int unsigned m_W, m_D, m_N;
   int unsigned mq[$];
   int unsigned m_tos;
   bit          m_ovf, m_unf;
   logic [31:0] bus_v[5];

   function automatic int unsigned o_tos();
      return (sel == 0) ? {16'h0, tos_a} : {24'h0, tos_b};
   endfunction
   function automatic int unsigned o_nos();
      return (sel == 0) ? {16'h0, nos_a} : {24'h0, nos_b};
   endfunction
   function automatic int unsigned o_cnt();
      return (sel == 0) ? {27'h0, cnt_a} : {29'h0, cnt_b};
   endfunction
   function automatic int unsigned o_full();
      return (sel == 0) ? {31'h0, full_a} : {31'h0, full_b};
   endfunction
   function automatic int unsigned o_empty();
      return (sel == 0) ? {31'h0, empty_a} : {31'h0, empty_b};
   endfunction
   function automatic int unsigned o_ovf();
      return (sel == 0) ? {31'h0, ovf_a} : {31'h0, ovf_b};
   endfunction
   function automatic int unsigned o_unf();
      return (sel == 0) ? {31'h0, unf_a} : {31'h0, unf_b};
   endfunction

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_tos = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic check_all(input string tag);
      int unsigned e_nos;
      e_nos = (mq.size() == 0) ? 0 : mq[mq.size()-1];
      chk({tag, ".tos"},   o_tos(),   m_tos);
      chk({tag, ".nos"},   o_nos(),   e_nos);
      chk({tag, ".count"}, o_cnt(),   mq.size());
      chk({tag, ".full"},  o_full(),  (mq.size() == m_D) ? 1 : 0);
      chk({tag, ".empty"}, o_empty(), (mq.size() == 0) ? 1 : 0);
      chk({tag, ".ovf"},   o_ovf(),   {31'h0, m_ovf});
      chk({tag, ".unf"},   o_unf(),   {31'h0, m_unf});
   endtask

   task automatic step(input logic [1:0] o, input logic trw, input int unsigned src,
                       input logic clr, input string tag);
      int unsigned s_val, t;
      op_a = 2'b00; trw_a = 1'b0; src_a = 3'd0; clr_a = 1'b0;
      op_b = 2'b00; trw_b = 1'b0; src_b = 2'd0; clr_b = 1'b0;
      for (int k = 0; k < 5; k++) bus_a[k*16 +: 16] = bus_v[k][15:0];
      for (int k = 0; k < 3; k++) bus_b[k*8 +: 8] = bus_v[k][7:0];
      if (sel == 0) begin
         op_a = o; trw_a = trw; src_a = src[2:0]; clr_a = clr;
      end else begin
         op_b = o; trw_b = trw; src_b = src[1:0]; clr_b = clr;
      end
      @(posedge CLK);
      #1;
      s_val = 0;
      if (src < m_N) s_val = bus_v[src] & ((32'd1 << m_W) - 1);
      if (clr) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      case (o)
         2'b00: if (trw) m_tos = s_val;
         2'b01: begin
            if (mq.size() == m_D) m_ovf = 1'b1;
            else begin
               mq.push_back(m_tos);
               if (trw) m_tos = s_val;
            end
         end
         2'b10: begin
            if (mq.size() == 0) m_unf = 1'b1;
            else begin
               t = mq.pop_back();
               m_tos = trw ? s_val : t;
            end
         end
         default: begin
            if (mq.size() == 0) m_unf = 1'b1;
            else begin
               t = mq[mq.size()-1];
               mq[mq.size()-1] = m_tos;
               m_tos = t;
            end
         end
      endcase
      check_all(tag);
   endtask

   // asynchronous reset pulse placed between clock edges
   task automatic do_reset(input string tag);
      #2 reset = 1'b1;
      #1 model_reset();
      check_all(tag);
      chk({tag, ".nos0"}, o_nos(), 0);
      @(negedge CLK);
      reset = 1'b0;
   endtask

   task automatic rand_run(input int n, input int unsigned src_max);
      int unsigned r;
      logic [1:0] o;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 5; k++) bus_v[k] = $urandom;
         r = $urandom_range(0, 9);
         // push-heavy first half, pop-heavy second half to reach both ends
         if (i < n / 2) o = (r < 6) ? OP_PUSH : 2'(r % 4);
         else           o = (r < 6) ? OP_POP  : 2'(r % 4);
         step(o, 1'($urandom_range(0, 1)), $urandom_range(0, src_max),
              ($urandom_range(0, 15) == 0), "rnd");
      end
   endtask

   initial begin
      sel = 0; m_W = 16; m_D = 16; m_N = 5;
      model_reset();
      for (int k = 0; k < 5; k++) bus_v[k] = k + 1;
      op_a = 2'b00; trw_a = 1'b0; src_a = 3'd0; clr_a = 1'b0; bus_a = '0;
      op_b = 2'b00; trw_b = 1'b0; src_b = 2'd0; clr_b = 1'b0; bus_b = '0;
      #3 check_all("rst0");
      @(negedge CLK);
      reset = 1'b0;

      // 1. reset mid-stream
      step(OP_PUSH, 1'b1, 0, 1'b0, "t1_p1");
      step(OP_PUSH, 1'b1, 1, 1'b0, "t1_p2");
      step(OP_PUSH, 1'b1, 2, 1'b0, "t1_p3");
      chk("t1_cnt3", o_cnt(), 3);
      do_reset("t1_async");

      // 2. load and push, src_bus = {5,4,3,2,1}
      step(OP_NOP, 1'b1, 2, 1'b0, "t2_ld");
      chk("t2_ld_tos", o_tos(), 3);
      step(OP_PUSH, 1'b1, 4, 1'b0, "t2_push");
      chk("t2_tos", o_tos(), 5);
      chk("t2_nos", o_nos(), 3);
      chk("t2_cnt", o_cnt(), 1);

      // 3. pop, then dup
      step(OP_POP, 1'b0, 0, 1'b0, "t3_pop");
      chk("t3_pop_tos", o_tos(), 3);
      chk("t3_pop_empty", o_empty(), 1);
      step(OP_PUSH, 1'b0, 0, 1'b0, "t3_dup");
      chk("t3_dup_tos", o_tos(), 3);
      chk("t3_dup_nos", o_nos(), 3);

      // 4. fill and overflow
      do_reset("t4_rst");
      for (int i = 1; i <= 16; i++) begin
         bus_v[0] = i;
         step(OP_PUSH, 1'b1, 0, 1'b0, "t4_fill");
      end
      chk("t4_full", o_full(), 1);
      chk("t4_nos", o_nos(), 15);
      chk("t4_tos", o_tos(), 16);
      bus_v[0] = 99;
      step(OP_PUSH, 1'b1, 0, 1'b0, "t4_ovf");
      chk("t4_ovf", o_ovf(), 1);
      chk("t4_ovf_tos", o_tos(), 16);
      chk("t4_ovf_cnt", o_cnt(), 16);
      step(OP_NOP, 1'b0, 0, 1'b1, "t4_clr");
      chk("t4_clr_ovf", o_ovf(), 0);

      // 5. underflow and clear/set collision
      do_reset("t5_rst");
      bus_v[0] = 42;
      step(OP_NOP, 1'b1, 0, 1'b0, "t5_ld");
      step(OP_POP, 1'b0, 0, 1'b0, "t5_pop");
      chk("t5_unf", o_unf(), 1);
      chk("t5_tos", o_tos(), 42);
      step(OP_NOP, 1'b0, 0, 1'b1, "t5_clr");
      step(OP_SWAP, 1'b0, 0, 1'b0, "t5_swap");
      chk("t5_swap_unf", o_unf(), 1);
      step(OP_POP, 1'b1, 0, 1'b1, "t5_clrset");
      chk("t5_clrset_unf", o_unf(), 1);
      chk("t5_clrset_tos", o_tos(), 42);

      // 6. swap, tr_write ignored
      bus_v[0] = 9;
      step(OP_NOP, 1'b1, 0, 1'b0, "t6_ld9");
      bus_v[0] = 7;
      step(OP_PUSH, 1'b1, 0, 1'b0, "t6_p7");
      step(OP_SWAP, 1'b1, 0, 1'b0, "t6_swap");
      chk("t6_tos", o_tos(), 9);
      chk("t6_nos", o_nos(), 7);
      chk("t6_cnt", o_cnt(), 1);

      rand_run(400, 7);

      // small geometry
      sel = 1; m_W = 8; m_D = 4; m_N = 3;
      do_reset("s_rst");
      for (int k = 0; k < 5; k++) bus_v[k] = k + 1;
      step(OP_NOP, 1'b1, 2, 1'b0, "s2_ld");
      chk("s2_ld_tos", o_tos(), 3);
      step(OP_PUSH, 1'b1, 1, 1'b0, "s2_push");
      chk("s2_tos", o_tos(), 2);
      chk("s2_nos", o_nos(), 3);
      step(OP_NOP, 1'b1, 3, 1'b0, "s_src3");
      chk("s_src3_tos", o_tos(), 0);
      do_reset("s4_rst");
      for (int i = 1; i <= 4; i++) begin
         bus_v[0] = 32'h100 + i;
         step(OP_PUSH, 1'b1, 0, 1'b0, "s4_fill");
      end
      chk("s4_full", o_full(), 1);
      chk("s4_nos", o_nos(), 3);
      chk("s4_tos", o_tos(), 4);
      step(OP_PUSH, 1'b1, 0, 1'b0, "s4_ovf");
      chk("s4_ovf", o_ovf(), 1);
      chk("s4_ovf_cnt", o_cnt(), 4);
      step(OP_NOP, 1'b0, 0, 1'b1, "s4_clr");

      rand_run(300, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
